rv_fetch_stage: RTL and testbench

//  Parametrised IF stage for the RV32I pipeline. It replaces the PC mux, PC register, PC+4 adder and IF/ID register.

---
 rtl/rv_fetch_pkg.sv | 23 ++
 rtl/rv_fetch_fifo.sv | 71 +++++++
 rtl/rv_fetch_stage.sv | 142 ++++++++++++++
 tb/tb_rv_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared constants and helpers for the RV32I instruction-fetch stage.
package rv_fetch_pkg;

    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } fetch_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous show-ahead FIFO for fetched entries; clear may coincide with a push,
// in which case the pushed word becomes the sole entry.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_wr_addr;
    logic             w_pop;
    logic             w_full;

    assign o_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_count   = r_cnt;
    assign o_data    = r_mem[r_rptr];
    assign w_pop     = i_pop & ~o_empty;
    assign w_wr_addr = i_clear ? '0 : r_wptr;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_clear) begin
            r_rptr <= '0;
            r_wptr <= i_push ? PTR_W'(1) : '0;
            r_cnt  <= i_push ? CNT_W'(1) : '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (i_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!i_push && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Upstream credit accounting must never let a lone push hit a full FIFO.
    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_clear && !w_pop && w_full));

endmodule

// File: rtl/rv_fetch_stage.sv
// RV32I IF stage: PC, credit-limited imem request/grant port, prefetch FIFO to decode.
// Optional FETCH_MISALIGN_EN: misaligned redirects emit a faulting NOP and halt fetch.
module rv_fetch_stage
    import rv_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSN_W   = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INSN_W-1:0] id_instr,
    output logic [PC_W-1:0]   id_pc,
    output logic [PC_W-1:0]   id_pc_plus4,
    output logic              id_fault
);

    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSN_W-1:0] instr;
        logic [PC_W-1:0]   pc;
`ifdef FETCH_MISALIGN_EN
        logic              fault;
`endif
    } entry_t;

    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic [CNT_W:0]   w_inflight;
    logic [PC_W-1:0]  w_redir_pc;
    logic             w_run;
    logic             w_misalign;
    logic             w_fire;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    entry_t           w_push_entry;
    entry_t           w_head;

`ifdef FETCH_MISALIGN_EN
    fetch_state_e r_state;
    assign w_run      = (r_state == StRun);
    assign w_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc = redirect_pc;
    assign id_fault   = w_head.fault;
`else
    assign w_run      = 1'b1;
    assign w_misalign = 1'b0;
    assign w_redir_pc = redirect_pc & ~PC_W'(3);
    assign id_fault   = 1'b0;
`endif

    // Credits: FIFO entries plus in-flight requests never exceed DEPTH.
    assign w_inflight = {1'b0, w_fifo_cnt} + {1'b0, r_outstanding};
    assign imem_req   = rst_n & w_run & ~redirect_valid & (w_inflight < (CNT_W + 1)'(DEPTH));
    assign imem_addr  = r_fetch_pc;
    assign w_fire     = imem_req & imem_gnt;

    assign w_push = redirect_valid ? w_misalign : (imem_rvalid & (r_drop_cnt == '0));
    assign w_pop  = id_valid & id_ready & ~redirect_valid;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.instr = imem_rdata;
        w_push_entry.pc    = r_resp_pc;
`ifdef FETCH_MISALIGN_EN
        if (w_misalign) begin
            w_push_entry.instr = INSN_W'(INSN_NOP);
            w_push_entry.pc    = redirect_pc;
            w_push_entry.fault = 1'b1;
        end
`endif
    end

    rv_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_fifo_cnt)
    );

    assign id_valid    = ~w_empty;
    assign id_instr    = w_head.instr;
    assign id_pc       = w_head.pc;
    assign id_pc_plus4 = w_head.pc + PC_W'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_EN
            r_state       <= StRun;
`endif
        end else if (redirect_valid) begin
            // Every word still in flight belongs to the abandoned path.
            r_fetch_pc    <= w_redir_pc;
            r_resp_pc     <= w_redir_pc;
            r_outstanding <= r_outstanding - CNT_W'(imem_rvalid);
            r_drop_cnt    <= r_outstanding - CNT_W'(imem_rvalid);
`ifdef FETCH_MISALIGN_EN
            r_state       <= w_misalign ? StHalt : StRun;
`endif
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_W'(4);
            end
            r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(imem_rvalid);
            if (imem_rvalid) begin
                if (r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end else begin
                    r_resp_pc <= r_resp_pc + PC_W'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Randomized bench for rv_fetch_stage: an in-order memory model plus a queue of the
// words decode should see, tagged by redirect epoch so stale responses are known.
module tb_rv_fetch_stage;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INSN_W-1:0] imem_rdata;
    logic              id_valid;
    logic              id_ready;
    logic [INSN_W-1:0] id_instr;
    logic [PC_W-1:0]   id_pc;
    logic [PC_W-1:0]   id_pc_plus4;
    logic              id_fault;

    always #5 clk = ~clk;

    rv_fetch_stage #(
        .PC_W     (PC_W),
        .INSN_W   (INSN_W),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_fault       (id_fault)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        int         epoch;
    } pend_t;

    exp_t       exp_q[$];
    pend_t      pend_q[$];
    logic [7:0] exp_fetch;
    bit         halted;
    int         epoch;
    int         checks;
    int         errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {a ^ 8'hA5, 8'h3C, ~a, a};
    endfunction

    task automatic do_reset(input int n);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        id_ready       = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("rst_req", 32'(imem_req), 32'd0);
            check_eq("rst_valid", 32'(id_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        pend_q.delete();
        exp_q.delete();
        exp_fetch = 8'h00;
        halted    = 1'b0;
        epoch++;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit gnt, input bit rv_try, input bit rdy, input bit redir,
                         input logic [7:0] tgt);
        bit    exp_req;
        bit    fire;
        pend_t p;
        exp_t  e;
        imem_gnt       = gnt;
        imem_rvalid    = rv_try && (pend_q.size() > 0);
        imem_rdata     = imem_rvalid ? word_of(pend_q[0].addr) : $urandom;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        @(negedge clk);
        exp_req = !redir && !halted && (exp_q.size() + pend_q.size() < DEPTH);
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        check_eq("id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e = exp_q[0];
            check_eq("id_pc", 32'(id_pc), 32'(e.pc));
            check_eq("id_pc_plus4", 32'(id_pc_plus4), 32'(8'(e.pc + 8'd4)));
            check_eq("id_instr", id_instr, e.instr);
            check_eq("id_fault", 32'(id_fault), 32'(e.fault));
        end
        fire = exp_req && gnt;
        if (!redir && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
        if (imem_rvalid) begin
            p = pend_q.pop_front();
            if (!redir && p.epoch == epoch) begin
                e.pc    = p.addr;
                e.instr = word_of(p.addr);
                e.fault = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (fire) begin
            p.addr  = exp_fetch;
            p.epoch = epoch;
            pend_q.push_back(p);
            exp_fetch = exp_fetch + 8'd4;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            exp_fetch = tgt & 8'hFC;
            halted    = 1'b0;
`ifdef FETCH_MISALIGN_EN
            if (tgt[1:0] != 2'b00) begin
                e.pc    = tgt;
                e.instr = 32'h0000_0013;
                e.fault = 1'b1;
                exp_q.push_back(e);
                halted = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        epoch  = 0;
        do_reset(2);
        stream(20);
        // Decode stalls; credits run out, then the backlog drains in order.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        stream(10);
        // Two grants with no responses, then redirect while a response lands.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
        stream(10);
        // PC wraps past 0xFC.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'hF4);
        stream(12);
        // Reset with requests in flight; their responses are never returned.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        do_reset(2);
        stream(8);
`ifdef FETCH_MISALIGN_EN
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h44);
        stream(8);
`endif
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                  ($urandom % 20) == 0, 8'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
